// File: rtl/cube_paint_sched.sv
// cube_paint_sched: queues SPI colour updates in a small FIFO and writes them
// into the shared cube colour table. The display reader normally owns the
// table port. A starvation counter forces a write through after STARVE_MAX
// deferred cycles so that queued updates always complete.
module cube_paint_sched #(
  parameter int NCUBES     = 28,
  parameter int DEPTH      = 4,
  parameter int ADDR_W     = 5,
  parameter int STARVE_MAX = 15
) (
  input  logic              theClock,
  input  logic              theReset,
  input  logic              Trigger,
  input  logic [7:0]        ImgNum,
  input  logic [7:0]        Red,
  input  logic [7:0]        Green,
  input  logic [7:0]        Blue,
  input  logic              Clr_err,
  input  logic              Disp_req,
  input  logic [ADDR_W-1:0] Disp_addr,
  output logic              Disp_gnt,
  output logic              Tbl_we,
  output logic [ADDR_W-1:0] Tbl_addr,
  output logic [23:0]       Tbl_wdata,
  output logic              Write_done,
  output logic [7:0]        Sched_status
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [7:0]       NCUBES_C = 8'(NCUBES);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [3:0]       STARVE_C = 4'(STARVE_MAX);

  typedef enum logic [1:0] {S_Idle, S_Write, S_Gap} state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [23:0]       rgb;
  } entry_t;

  state_t           state, next_state;
  entry_t           mem [DEPTH];
  entry_t           head;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic [3:0]       starve_cnt;
  logic             overflow, bad_index;
  logic             idx_bad, fifo_full, push, pop, write_ok;
  logic             new_bad, new_ovf, busy;

  // Capture qualification: an out-of-range index beats a full FIFO.
  assign idx_bad   = ImgNum >= NCUBES_C;
  assign fifo_full = count == DEPTH_C;
  assign push      = Trigger & ~idx_bad & ~fifo_full;
  assign new_bad   = Trigger & idx_bad;
  assign new_ovf   = Trigger & ~idx_bad & fifo_full;
  assign head      = mem[rd_ptr];

  // Next-state and port arbitration: the display owns the port unless a write issues.
  always_comb begin
    // NOTE: every output of this block is given a default first so no path infers a latch.
    next_state = state;
    write_ok   = ~Disp_req | (starve_cnt == STARVE_C);
    pop        = 1'b0;
    Tbl_we     = 1'b0;
    Disp_gnt   = Disp_req;
    Write_done = 1'b0;
    case (state)
      S_Idle: begin
        if (count != '0) next_state = S_Write;
      end
      S_Write: begin
        if (write_ok) begin
          Tbl_we     = 1'b1;
          pop        = 1'b1;
          Disp_gnt   = 1'b0;
          next_state = S_Gap;
        end
      end
      S_Gap: begin
        Write_done = 1'b1;
        next_state = (count != '0) ? S_Write : S_Idle;
      end
      default: next_state = S_Idle;
    endcase
  end

  assign Tbl_addr     = Tbl_we ? head.addr : Disp_addr;
  assign Tbl_wdata    = head.rgb;
  assign busy         = (state != S_Idle) | (count != '0);
  assign Sched_status = {busy, overflow, bad_index, 2'b00, 3'(count)};

  // State register and starvation counter.
  always_ff @(posedge theClock or posedge theReset) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (theReset) begin
      state      <= S_Idle;
      starve_cnt <= '0;
    end else begin
      state <= next_state;
      if (state == S_Write) begin
        if (write_ok) starve_cnt <= '0;
        else          starve_cnt <= starve_cnt + 4'd1;
      end
    end
  end

  // FIFO pointers and occupancy; push and pop in one cycle leave count unchanged.
  always_ff @(posedge theClock or posedge theReset) begin
    if (theReset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // FIFO storage.
  always_ff @(posedge theClock) begin
    // NOTE: storage is not reset; pointers and count alone define which entries are valid.
    if (push) mem[wr_ptr] <= '{addr: ImgNum[ADDR_W-1:0], rgb: {Red, Green, Blue}};
  end

  // Sticky error flags; a new error in the clearing cycle keeps the flag set.
  always_ff @(posedge theClock or posedge theReset) begin
    if (theReset) begin
      overflow  <= 1'b0;
      bad_index <= 1'b0;
    end else begin
      overflow  <= (overflow  & ~Clr_err) | new_ovf;
      bad_index <= (bad_index & ~Clr_err) | new_bad;
    end
  end

endmodule

// File: tb/tb_cube_paint_sched.sv
// Bench for cube_paint_sched: directed stimulus, a queue-based reference model
// checked on every falling edge, and literal expectations at key points.
module tb_cube_paint_sched;

  logic       theClock = 1'b0;
  logic       theReset;
  logic       Trigger, Clr_err, Disp_req;
  logic [7:0] ImgNum, Red, Green, Blue;
  logic [4:0] Disp_addr;
  logic       Disp_gnt, Tbl_we, Write_done;
  logic [4:0] Tbl_addr;
  logic [23:0] Tbl_wdata;
  logic [7:0] Sched_status;

  int n_vec = 0;
  int n_err = 0;

  cube_paint_sched dut (
    .theClock(theClock), .theReset(theReset), .Trigger(Trigger), .ImgNum(ImgNum),
    .Red(Red), .Green(Green), .Blue(Blue), .Clr_err(Clr_err), .Disp_req(Disp_req),
    .Disp_addr(Disp_addr), .Disp_gnt(Disp_gnt), .Tbl_we(Tbl_we), .Tbl_addr(Tbl_addr),
    .Tbl_wdata(Tbl_wdata), .Write_done(Write_done), .Sched_status(Sched_status)
  );

  always #5 theClock = ~theClock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge theClock);
    #1;
  endtask

  // Reference model: pending updates as a queue, plus the few facts the
  // scheduling rules depend on. A write needs its entry queued for a whole
  // cycle beforehand, writes are at least two cycles apart, and a deferred
  // write wins the port once the display has been served 15 times in a row.
  logic [28:0] mq[$];
  logic [4:0]  wr_log[$];
  bit          m_prev_ne, m_wrote, m_ovf, m_bad;
  int          m_starve, m_sz;
  bit          m_elig, m_do_wr, m_busy;
  logic [4:0]  m_addr;

  always @(negedge theClock) begin
    if (theReset) begin
      mq.delete();
      m_prev_ne = 0; m_wrote = 0; m_ovf = 0; m_bad = 0; m_starve = 0;
    end else begin
      m_sz    = mq.size();
      m_elig  = (m_sz != 0) && m_prev_ne && !m_wrote;
      m_do_wr = m_elig && (!Disp_req || m_starve == 15);
      m_busy  = (m_sz != 0) || m_wrote;
      m_addr  = Disp_addr;
      if (m_do_wr) m_addr = mq[0][28:24];
      check("tbl_we", 32'(Tbl_we), 32'(m_do_wr));
      check("disp_gnt", 32'(Disp_gnt), 32'(Disp_req && !m_do_wr));
      check("write_done", 32'(Write_done), 32'(m_wrote));
      check("tbl_addr", 32'(Tbl_addr), 32'(m_addr));
      if (m_do_wr) check("tbl_wdata", 32'(Tbl_wdata), 32'(mq[0][23:0]));
      check("status", 32'(Sched_status), 32'({m_busy, m_ovf, m_bad, 2'b00, 3'(m_sz)}));
      if (Tbl_we) wr_log.push_back(Tbl_addr);
      m_prev_ne = (m_sz != 0);
      m_wrote   = m_do_wr;
      if (m_do_wr) begin
        void'(mq.pop_front());
        m_starve = 0;
      end else if (m_elig) begin
        m_starve++;
      end
      if (Clr_err) begin m_ovf = 0; m_bad = 0; end
      if (Trigger) begin
        if (ImgNum >= 8'd28)  m_bad = 1;
        else if (m_sz == 4)   m_ovf = 1;
        else                  mq.push_back({ImgNum[4:0], Red, Green, Blue});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    logic [4:0] exp_ord [4];
    int gnt_cnt;
    bit seen;
    int n;
    exp_ord = '{5'd0, 5'd1, 5'd2, 5'd3};

    theReset = 1'b1; Trigger = 0; Clr_err = 0; Disp_req = 0;
    ImgNum = 0; Red = 0; Green = 0; Blue = 0; Disp_addr = 5'd9;
    #3;
    check("rst_status", 32'(Sched_status), 32'h00);
    check("rst_we", 32'(Tbl_we), 32'h0);
    check("rst_done", 32'(Write_done), 32'h0);
    repeat (2) tick();
    theReset = 1'b0;
    repeat (2) tick();

    // Single update.
    Trigger = 1; ImgNum = 8'd5; Red = 8'h11; Green = 8'h22; Blue = 8'h33;
    tick(); Trigger = 0; #1;
    check("single_t1_status", 32'(Sched_status), 32'h81);
    check("single_t1_we", 32'(Tbl_we), 32'h0);
    tick(); #1;
    check("single_t2_we", 32'(Tbl_we), 32'h1);
    check("single_t2_addr", 32'(Tbl_addr), 32'd5);
    check("single_t2_wdata", 32'(Tbl_wdata), 32'h112233);
    tick(); #1;
    check("single_t3_done", 32'(Write_done), 32'h1);
    tick(); #1;
    check("single_t4_status", 32'(Sched_status), 32'h00);

    // Overflow while the display holds the port.
    Disp_req = 1; Disp_addr = 5'd17;
    for (int i = 0; i < 6; i++) begin
      Trigger = 1; ImgNum = 8'(i); Red = 8'(i * 3); Green = 8'(i + 64); Blue = 8'hA0 ^ 8'(i);
      tick();
    end
    Trigger = 0; #1;
    check("ovf_status", 32'(Sched_status), 32'hC4);
    wr_log.delete();
    Disp_req = 0;
    repeat (10) tick();
    check("ovf_nwrites", 32'(wr_log.size()), 32'd4);
    for (int i = 0; i < 4 && i < wr_log.size(); i++) check("ovf_order", 32'(wr_log[i]), 32'(exp_ord[i]));
    check("ovf_sticky", 32'(Sched_status), 32'h40);
    Clr_err = 1; tick(); Clr_err = 0; #1;
    check("ovf_cleared", 32'(Sched_status), 32'h00);

    // Bad index, then set-wins against a clear.
    Trigger = 1; ImgNum = 8'd28;
    tick(); Trigger = 0; #1;
    check("bad_status", 32'(Sched_status), 32'h20);
    tick();
    Trigger = 1; ImgNum = 8'd30; Clr_err = 1;
    tick(); Trigger = 0; Clr_err = 0; #1;
    check("bad_setwins", 32'(Sched_status), 32'h20);
    Clr_err = 1; tick(); Clr_err = 0; #1;
    check("bad_cleared", 32'(Sched_status), 32'h00);

    // Starvation guard.
    Disp_req = 1; Disp_addr = 5'd3;
    Trigger = 1; ImgNum = 8'd7; Red = 8'hC1; Green = 8'hC2; Blue = 8'hC3;
    tick(); Trigger = 0;
    tick();
    gnt_cnt = 0; seen = 0;
    for (int c = 0; c < 40 && !seen; c++) begin
      #1;
      if (Tbl_we) begin
        seen = 1;
        check("starve_forced_gnt", 32'(Disp_gnt), 32'h0);
        check("starve_forced_addr", 32'(Tbl_addr), 32'd7);
      end else if (Disp_gnt) begin
        gnt_cnt++;
      end
      if (!seen) tick();
    end
    check("starve_seen", 32'(seen), 32'h1);
    check("starve_gnt_cycles", 32'(gnt_cnt), 32'd15);
    tick(); #1;
    check("starve_after_gnt", 32'(Disp_gnt), 32'h1);
    Disp_req = 0;
    repeat (3) tick();

    // Push and pop in the same cycle, FIFO order across pointer wrap.
    wr_log.delete();
    n = 0;
    for (int k = 0; k < 17; k++) begin
      if (k <= 2 || k % 2 == 0) begin
        Trigger = 1; ImgNum = 8'(10 + n); Red = 8'(10 + n); Green = ~8'(10 + n); Blue = 8'(10 + n) ^ 8'h5A;
        n++;
      end else begin
        Trigger = 0;
      end
      #1;
      if (k == 2) begin
        check("pp_we", 32'(Tbl_we), 32'h1);
        check("pp_status_k2", 32'(Sched_status), 32'h82);
      end
      if (k == 3) check("pp_status_k3", 32'(Sched_status), 32'h82);
      tick();
    end
    Trigger = 0;
    repeat (12) tick();
    check("pp_nwrites", 32'(wr_log.size()), 32'd10);
    for (int i = 0; i < 10 && i < wr_log.size(); i++) check("pp_order", 32'(wr_log[i]), 32'(10 + i));

    // Asynchronous reset in the middle of a write.
    wr_log.delete();
    Disp_req = 1;
    for (int i = 1; i <= 3; i++) begin
      Trigger = 1; ImgNum = 8'(i); Red = 8'h55; Green = 8'(i); Blue = 8'hEE;
      tick();
    end
    Trigger = 0; Disp_req = 0; #1;
    check("rstmid_we_before", 32'(Tbl_we), 32'h1);
    check("rstmid_status_before", 32'(Sched_status), 32'h83);
    #1 theReset = 1'b1;
    #1;
    check("rstmid_we_after", 32'(Tbl_we), 32'h0);
    check("rstmid_status_after", 32'(Sched_status), 32'h00);
    tick();
    theReset = 1'b0;
    repeat (10) tick();
    check("rstmid_no_writes", 32'(wr_log.size()), 32'd0);
    check("rstmid_idle_status", 32'(Sched_status), 32'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
